// File: rtl/reg_file_rename.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_file_rename                                                 |
// | Brief    : Architectural register file with per-register rename tags,      |
// |            commit bypass and reorder-buffer flush.                         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module reg_file_rename #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int REG_COUNT    = 32,
  parameter int XLEN         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reset_from_rob_bus,
  input  logic                    valid_from_issuer,
  input  logic [4:0]              rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [4:0]              rs1_from_issuer,
  input  logic [4:0]              rs2_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [XLEN-1:0]         vj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [XLEN-1:0]         vk_to_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_ro_buffer,
  input  logic [4:0]              rd_from_ro_buffer,
  input  logic [XLEN-1:0]         value_from_ro_buffer
);

  localparam int c_lookup_w = ROB_ID_WIDTH + XLEN;

  logic [XLEN-1:0]         r_value [REG_COUNT];
  logic [ROB_ID_WIDTH-1:0] r_tag   [REG_COUNT];

  logic w_commit_valid;
  logic w_commit_write;
  logic w_issue_write;
  logic [c_lookup_w-1:0] w_lookup_j;
  logic [c_lookup_w-1:0] w_lookup_k;

  assign w_commit_valid = (dest_from_ro_buffer != '0);
  assign w_commit_write = w_commit_valid && (rd_from_ro_buffer != 5'd0) &&
                          (32'(rd_from_ro_buffer) < REG_COUNT);
  assign w_issue_write  = valid_from_issuer && !reset_from_rob_bus &&
                          (rd_from_issuer != 5'd0) &&
                          (32'(rd_from_issuer) < REG_COUNT);

  // Returns {q, v}; a retiring producer is forwarded so the issuer never waits on it.
  function automatic logic [c_lookup_w-1:0] lookup(input logic [4:0] rs);
    lookup = '0;
    if (rs != 5'd0 && 32'(rs) < REG_COUNT) begin
      if (w_commit_valid && rd_from_ro_buffer == rs && r_tag[rs] == dest_from_ro_buffer)
        lookup = {{ROB_ID_WIDTH{1'b0}}, value_from_ro_buffer};
      else
        lookup = {r_tag[rs], r_value[rs]};
    end
  endfunction

  always_comb begin
    w_lookup_j = lookup(rs1_from_issuer);
    w_lookup_k = lookup(rs2_from_issuer);
  end

  assign qj_to_issuer = w_lookup_j[c_lookup_w-1:XLEN];
  assign vj_to_issuer = w_lookup_j[XLEN-1:0];
  assign qk_to_issuer = w_lookup_k[c_lookup_w-1:XLEN];
  assign vk_to_issuer = w_lookup_k[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
    end else if (rdy) begin
      if (w_commit_write)
        r_value[rd_from_ro_buffer] <= value_from_ro_buffer;
      if (reset_from_rob_bus) begin
        for (int i = 0; i < REG_COUNT; i++)
          r_tag[i] <= '0;
      end else begin
        if (w_commit_write && r_tag[rd_from_ro_buffer] == dest_from_ro_buffer)
          r_tag[rd_from_ro_buffer] <= '0;
        // Issued later in this block so a same-cycle rename of the same rd wins.
        if (w_issue_write)
          r_tag[rd_from_issuer] <= dest_from_issuer;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_rename.sv
`default_nettype none
// Testbench for reg_file_rename: vector table with expected read results
// queued at drive time and compared before the following clock edge.
module tb_reg_file_rename;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        reset_from_rob_bus = 1'b0;
  logic        valid_from_issuer = 1'b0;
  logic [4:0]  rd_from_issuer = '0;
  logic [3:0]  dest_from_issuer = '0;
  logic [4:0]  rs1_from_issuer = '0;
  logic [4:0]  rs2_from_issuer = '0;
  logic [3:0]  qj_to_issuer;
  logic [31:0] vj_to_issuer;
  logic [3:0]  qk_to_issuer;
  logic [31:0] vk_to_issuer;
  logic [3:0]  dest_from_ro_buffer = '0;
  logic [4:0]  rd_from_ro_buffer = '0;
  logic [31:0] value_from_ro_buffer = '0;

  reg_file_rename #(.ROB_ID_WIDTH(4), .REG_COUNT(32), .XLEN(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .reset_from_rob_bus   (reset_from_rob_bus),
    .valid_from_issuer    (valid_from_issuer),
    .rd_from_issuer       (rd_from_issuer),
    .dest_from_issuer     (dest_from_issuer),
    .rs1_from_issuer      (rs1_from_issuer),
    .rs2_from_issuer      (rs2_from_issuer),
    .qj_to_issuer         (qj_to_issuer),
    .vj_to_issuer         (vj_to_issuer),
    .qk_to_issuer         (qk_to_issuer),
    .vk_to_issuer         (vk_to_issuer),
    .dest_from_ro_buffer  (dest_from_ro_buffer),
    .rd_from_ro_buffer    (rd_from_ro_buffer),
    .value_from_ro_buffer (value_from_ro_buffer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, flush, iv;
    logic [4:0]  ird;
    logic [3:0]  idest;
    logic [4:0]  rs1, rs2;
    logic [3:0]  cdest;
    logic [4:0]  crd;
    logic [31:0] cval;
    logic [3:0]  qj;
    logic [31:0] vj;
    logic [3:0]  qk;
    logic [31:0] vk;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  qj;
    logic [31:0] vj;
    logic [3:0]  qk;
    logic [31:0] vk;
  } exp_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];
  exp_t sb [$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(input logic r, input logic fl, input logic iv,
                              input logic [4:0] ird, input logic [3:0] idest,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [3:0] cdest, input logic [4:0] crd,
                              input logic [31:0] cval,
                              input logic [3:0] qj, input logic [31:0] vj,
                              input logic [3:0] qk, input logic [31:0] vk);
    vec_t v;
    v.rdy = r; v.flush = fl; v.iv = iv; v.ird = ird; v.idest = idest;
    v.rs1 = rs1; v.rs2 = rs2; v.cdest = cdest; v.crd = crd; v.cval = cval;
    v.qj = qj; v.vj = vj; v.qk = qk; v.vk = vk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; reset_from_rob_bus = 1'b0; valid_from_issuer = 1'b0;
    rd_from_issuer = '0; dest_from_issuer = '0;
    dest_from_ro_buffer = '0; rd_from_ro_buffer = '0; value_from_ro_buffer = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //                 rdy fl iv ird idest rs1 rs2 cdest crd cval        qj vj          qk vk
    vecs[0]  = mk(1, 0, 0, 0,  0, 5,  0,  0, 0,  32'h0,      0, 32'h0,      0, 32'h0);
    vecs[1]  = mk(1, 0, 0, 0,  0, 0,  0,  3, 0,  32'hDEAD,   0, 32'h0,      0, 32'h0);
    vecs[2]  = mk(1, 0, 1, 7,  2, 7,  5,  0, 0,  32'h0,      0, 32'h0,      0, 32'h0);
    vecs[3]  = mk(1, 0, 0, 0,  0, 7,  0,  0, 0,  32'h0,      2, 32'h0,      0, 32'h0);
    vecs[4]  = mk(1, 0, 0, 0,  0, 7,  7,  2, 7,  32'h1234,   0, 32'h1234,   0, 32'h1234);
    vecs[5]  = mk(1, 0, 0, 0,  0, 7,  0,  0, 0,  32'h0,      0, 32'h1234,   0, 32'h0);
    vecs[6]  = mk(1, 0, 1, 4,  1, 4,  0,  0, 0,  32'h0,      0, 32'h0,      0, 32'h0);
    vecs[7]  = mk(1, 0, 1, 4,  3, 4,  0,  0, 0,  32'h0,      1, 32'h0,      0, 32'h0);
    vecs[8]  = mk(1, 0, 0, 0,  0, 4,  0,  1, 4,  32'h55,     3, 32'h0,      0, 32'h0);
    vecs[9]  = mk(1, 0, 0, 0,  0, 4,  0,  0, 0,  32'h0,      3, 32'h55,     0, 32'h0);
    vecs[10] = mk(1, 0, 1, 9,  5, 9,  0,  0, 0,  32'h0,      0, 32'h0,      0, 32'h0);
    vecs[11] = mk(1, 0, 1, 9,  6, 9,  4,  5, 9,  32'hAA,     0, 32'hAA,     3, 32'h55);
    vecs[12] = mk(1, 0, 1, 1,  1, 9,  0,  0, 0,  32'h0,      6, 32'hAA,     0, 32'h0);
    vecs[13] = mk(1, 0, 1, 2,  2, 1,  0,  0, 0,  32'h0,      1, 32'h0,      0, 32'h0);
    vecs[14] = mk(1, 0, 1, 3,  3, 2,  1,  0, 0,  32'h0,      2, 32'h0,      1, 32'h0);
    vecs[15] = mk(1, 1, 1, 10, 4, 3,  9,  0, 0,  32'h0,      3, 32'h0,      6, 32'hAA);
    vecs[16] = mk(1, 0, 0, 0,  0, 10, 4,  0, 0,  32'h0,      0, 32'h0,      0, 32'h55);
    vecs[17] = mk(1, 0, 0, 0,  0, 9,  7,  0, 0,  32'h0,      0, 32'hAA,     0, 32'h1234);
    vecs[18] = mk(1, 0, 1, 11, 7, 1,  3,  0, 0,  32'h0,      0, 32'h0,      0, 32'h0);
    vecs[19] = mk(1, 1, 0, 0,  0, 11, 0,  7, 11, 32'hBEEF,   0, 32'hBEEF,   0, 32'h0);
    vecs[20] = mk(1, 0, 0, 0,  0, 11, 0,  0, 0,  32'h0,      0, 32'hBEEF,   0, 32'h0);
    vecs[21] = mk(0, 0, 1, 8,  5, 8,  0,  5, 8,  32'h77,     0, 32'h0,      0, 32'h0);
    vecs[22] = mk(1, 0, 1, 0,  9, 8,  0,  0, 0,  32'h0,      0, 32'h0,      0, 32'h0);
    vecs[23] = mk(1, 0, 0, 0,  0, 0,  8,  0, 0,  32'h0,      0, 32'h0,      0, 32'h0);

    // Reset state: reads return zero while rst is held.
    idle_inputs();
    rs1_from_issuer = 5'd5; rs2_from_issuer = 5'd0;
    #2;
    check("reset_qj", 32'(qj_to_issuer), 32'h0);
    check("reset_vj", vj_to_issuer, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rdy = vecs[i].rdy; reset_from_rob_bus = vecs[i].flush;
      valid_from_issuer = vecs[i].iv; rd_from_issuer = vecs[i].ird;
      dest_from_issuer = vecs[i].idest;
      rs1_from_issuer = vecs[i].rs1; rs2_from_issuer = vecs[i].rs2;
      dest_from_ro_buffer = vecs[i].cdest; rd_from_ro_buffer = vecs[i].crd;
      value_from_ro_buffer = vecs[i].cval;
      e.idx = i; e.qj = vecs[i].qj; e.vj = vecs[i].vj; e.qk = vecs[i].qk; e.vk = vecs[i].vk;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      check($sformatf("v%0d_qj", e.idx), 32'(qj_to_issuer), 32'(e.qj));
      check($sformatf("v%0d_vj", e.idx), vj_to_issuer, e.vj);
      check($sformatf("v%0d_qk", e.idx), 32'(qk_to_issuer), 32'(e.qk));
      check($sformatf("v%0d_vk", e.idx), vk_to_issuer, e.vk);
    end
    check("sb_empty", 32'(sb.size()), 32'h0);

    // Asynchronous reset mid-run clears values without a clock edge.
    @(negedge clk);
    idle_inputs();
    rs1_from_issuer = 5'd9; rs2_from_issuer = 5'd7;
    #1;
    check("pre_rst_vj", vj_to_issuer, 32'hAA);
    check("pre_rst_vk", vk_to_issuer, 32'h1234);
    rst = 1'b1;
    #1;
    check("async_rst_vj", vj_to_issuer, 32'h0);
    check("async_rst_vk", vk_to_issuer, 32'h0);

    // Issue held across an edge during reset must be ignored.
    valid_from_issuer = 1'b1; rd_from_issuer = 5'd12; dest_from_issuer = 4'd8;
    rs1_from_issuer = 5'd12;
    @(posedge clk); #1;
    check("rst_issue_qj", 32'(qj_to_issuer), 32'h0);

    // First edge after release behaves normally.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_qj", 32'(qj_to_issuer), 32'h8);
    @(negedge clk);
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
